// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response plus the decode-side buffer head.
interface fetch_unit_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_instr;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_instr;
  logic [CW-1:0]   buf_count;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_instr,
    output dec_valid, dec_pc, dec_instr, buf_count,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_instr,
    input  dec_valid, dec_pc, dec_instr, buf_count,
    output dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Credit-based instruction fetch: issues sequential PCs, tags in-order responses into a small
// buffer for decode, and flushes/drops stale responses on an execute-stage redirect.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_sel_ex,
  input  logic [XLEN-1:0] pc_ex,
  fetch_unit_if.master    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN   = ~XLEN'(3);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t          ibuf [DEPTH];
  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count, inflight, inflight_nxt, drop;
  logic [CW:0]     credit_used;
  logic            req_fire, rsp_keep, pop;

  // Buffered plus outstanding requests may never exceed the buffer size, so a push never finds it full.
  assign credit_used        = {1'b0, count} + {1'b0, inflight};
  assign bus.imem_req_valid = rst && !pc_sel_ex && (credit_used < DEPTH_C);
  assign bus.imem_req_addr  = fetch_pc;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_keep = bus.imem_rsp_valid && !pc_sel_ex && (drop == '0);
  assign pop      = bus.dec_valid && bus.dec_ready && !pc_sel_ex;

  assign bus.dec_valid = (count != '0);
  assign bus.dec_pc    = bus.dec_valid ? ibuf[head].pc    : '0;
  assign bus.dec_instr = bus.dec_valid ? ibuf[head].instr : '0;
  assign bus.buf_count = count;

  always_comb begin
    inflight_nxt = inflight;
    if (req_fire && !bus.imem_rsp_valid)      inflight_nxt = inflight + 1'b1;
    else if (!req_fire && bus.imem_rsp_valid) inflight_nxt = inflight - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (pc_sel_ex) begin
        // Everything still outstanding after this cycle belongs to the old path.
        fetch_pc <= pc_ex & ALIGN;
        rsp_pc   <= pc_ex & ALIGN;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        drop     <= inflight_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + STEP;
        if (bus.imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
        if (rsp_keep) begin
          rsp_pc <= rsp_pc + STEP;
          tail   <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
        if (rsp_keep && !pop)      count <= count + 1'b1;
        else if (!rsp_keep && pop) count <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset; the head is masked by dec_valid.
  always_ff @(posedge clk) begin
    if (rsp_keep) ibuf[tail] <= '{pc: rsp_pc, instr: bus.imem_rsp_instr};
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: memory model with configurable latency, decode sink, and
// a second instance started near the top of the address space.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_sel_ex = 1'b0;
  logic [31:0] pc_ex = '0;

  always #10 clk = ~clk;

  fetch_unit_if #(.XLEN(32), .DEPTH(4)) ifc ();
  fetch_unit_if #(.XLEN(32), .DEPTH(4)) wif ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc_sel_ex(pc_sel_ex), .pc_ex(pc_ex), .bus(ifc));

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst), .pc_sel_ex(1'b0), .pc_ex(32'h0), .bus(wif));

  int nerr = 0, nchk = 0, npop = 0, cyc = 0;
  int max_inflight = 0, max_bc = 0;
  int lat_min = 1, lat_max = 1, dr_mode = 1;
  bit rdy_rand = 0, junk_rsp = 0, rsp_now = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] waddr[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic load_exp(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  // Memory model: in-order responses, one per cycle, latency lat_min..lat_max.
  initial begin
    int due;
    ifc.imem_req_ready = 1'b0; ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_instr = '0;   ifc.dec_ready = 1'b0;
    forever begin
      @(negedge clk); #1;
      rsp_now = 0;
      if (!rst) begin
        mq_addr.delete(); mq_due.delete();
        ifc.imem_rsp_valid = junk_rsp;
        ifc.imem_rsp_instr = 32'hBAD0_BAD0;
        ifc.imem_req_ready = 1'b1;
        ifc.dec_ready      = 1'b1;
      end else begin
        rsp_now = (mq_due.size() > 0) && (mq_due[0] <= cyc);
        ifc.imem_rsp_valid = rsp_now;
        ifc.imem_rsp_instr = rsp_now ? (mq_addr[0] ^ KEY) : '0;
        ifc.imem_req_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
        case (dr_mode)
          0:       ifc.dec_ready = 1'b0;
          1:       ifc.dec_ready = 1'b1;
          default: ifc.dec_ready = 1'($urandom_range(1, 0));
        endcase
      end
      #1;
      if (rst) begin
        if (rsp_now) begin void'(mq_addr.pop_front()); void'(mq_due.pop_front()); end
        if (ifc.imem_req_valid && ifc.imem_req_ready) begin
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (mq_due.size() > 0 && due <= mq_due[$]) due = mq_due[$] + 1;
          mq_addr.push_back(ifc.imem_req_addr);
          mq_due.push_back(due);
        end
        if (mq_due.size() > max_inflight) max_inflight = mq_due.size();
      end
    end
  end

  // Monitor: every accepted decode beat is checked against the scoreboard head.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk); #3;
      if (int'(ifc.buf_count) > max_bc) max_bc = int'(ifc.buf_count);
      if (rst && ifc.dec_valid && ifc.dec_ready && !pc_sel_ex) begin
        npop++;
        if (exp_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_pop got pc=%h exp=none", ifc.dec_pc);
        end else begin
          e = exp_q.pop_front();
          check("dec_pc", ifc.dec_pc, e);
          check("dec_instr", ifc.dec_instr, e ^ KEY);
        end
      end
    end
  end

  // Second instance: always ready, never answers, so credit stops it after four requests.
  initial begin
    wif.imem_req_ready = 1'b1; wif.imem_rsp_valid = 1'b0;
    wif.imem_rsp_instr = '0;   wif.dec_ready = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (rst && wif.imem_req_valid && wif.imem_req_ready && waddr.size() < 8)
        waddr.push_back(wif.imem_req_addr);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    cycles(3); #4;
    check("rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    check("rst_dec_valid", 32'(ifc.dec_valid), 32'd0);
    check("rst_buf_count", 32'(ifc.buf_count), 32'd0);
    check("rst_dec_pc", ifc.dec_pc, 32'h0);
    check("rst_dec_instr", ifc.dec_instr, 32'h0);

    // Streaming from RESET_PC with 1-cycle latency.
    load_exp(32'h0, 64);
    @(negedge clk); rst = 1'b1; #4;
    check("first_req_valid", 32'(ifc.imem_req_valid), 32'd1);
    check("first_req_addr", ifc.imem_req_addr, 32'h0);
    cycles(10);
    p0 = npop;
    cycles(20);
    check("stream_rate", 32'(npop - p0), 32'd20);

    check("wrap_req_count", 32'(waddr.size()), 32'd4);
    if (waddr.size() == 4) begin
      check("wrap_addr0", waddr[0], 32'hFFFF_FFF8);
      check("wrap_addr1", waddr[1], 32'hFFFF_FFFC);
      check("wrap_addr2", waddr[2], 32'h0000_0000);
      check("wrap_addr3", waddr[3], 32'h0000_0004);
    end
    check("wrap_credit_stall", 32'(wif.imem_req_valid), 32'd0);

    // Back-pressure: decode stalls for 10 cycles.
    dr_mode = 0;
    cycles(10); #4;
    check("bp_buf_count", 32'(ifc.buf_count), 32'd4);
    check("bp_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    check("bp_head_pc", ifc.dec_pc, exp_q[0]);
    check("bp_head_instr", ifc.dec_instr, exp_q[0] ^ KEY);
    dr_mode = 1;
    cycles(12);

    // Redirect with requests outstanding at latency 3.
    lat_min = 3; lat_max = 3;
    cycles(15);
    @(negedge clk);
    pc_sel_ex = 1'b1; pc_ex = 32'h0000_0103;
    load_exp(32'h100, 1000);
    #4;
    check("redir_no_req", 32'(ifc.imem_req_valid), 32'd0);
    @(negedge clk); pc_sel_ex = 1'b0; #4;
    for (int i = 0; i < 10 && !ifc.imem_req_valid; i++) begin @(negedge clk); #4; end
    check("redir_req_valid", 32'(ifc.imem_req_valid), 32'd1);
    check("redir_req_addr", ifc.imem_req_addr, 32'h100);
    p0 = npop;
    cycles(30);
    check("redir_progress", 32'(npop - p0 >= 10), 32'd1);

    // Variable latency and random handshakes on both sides.
    rdy_rand = 1; lat_min = 1; lat_max = 5; dr_mode = 2;
    p0 = npop;
    cycles(300);
    check("var_progress", 32'(npop - p0 >= 20), 32'd1);
    check("max_inflight_le4", 32'(max_inflight <= 4), 32'd1);
    check("max_buf_count_le4", 32'(max_bc <= 4), 32'd1);

    // Reset mid-stream with requests outstanding.
    rdy_rand = 0; lat_min = 2; lat_max = 2; dr_mode = 1;
    cycles(10);
    @(negedge clk); #6;
    rst = 1'b0; #1;
    check("mid_rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    check("mid_rst_dec_valid", 32'(ifc.dec_valid), 32'd0);
    check("mid_rst_buf_count", 32'(ifc.buf_count), 32'd0);
    check("mid_rst_dec_pc", ifc.dec_pc, 32'h0);
    check("mid_rst_dec_instr", ifc.dec_instr, 32'h0);
    @(negedge clk); junk_rsp = 1;
    cycles(2);
    junk_rsp = 0; #4;
    check("junk_ignored_count", 32'(ifc.buf_count), 32'd0);
    check("junk_ignored_valid", 32'(ifc.dec_valid), 32'd0);
    load_exp(32'h0, 64);
    @(negedge clk); rst = 1'b1; #4;
    check("post_rst_req_addr", ifc.imem_req_addr, 32'h0);
    check("post_rst_req_valid", 32'(ifc.imem_req_valid), 32'd1);
    p0 = npop;
    cycles(20);
    check("post_rst_progress", 32'(npop - p0 >= 10), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
